// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-priority FIFO and its drain stage.
package fifo_pkg;

  // Source tag carried alongside each drained word
  localparam logic SRC_HP = 1'b1;
  localparam logic SRC_LP = 1'b0;

  // Default word width of the priority FIFO
  localparam int unsigned FIFO_DATA_WIDTH = 16;

  // Index width for a buffer of 'depth' entries (at least one bit)
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/drain_out_buf.sv
// Circular output buffer for the drain stage. Pointers carry one extra
// wrap bit so full and empty are distinguishable without a separate count.
module drain_out_buf
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = FIFO_DATA_WIDTH + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    rd_en,
  output logic [WIDTH-1:0]        rd_data,
  output logic [ptr_w(DEPTH):0]   occ
);

  localparam int unsigned   AW      = ptr_w(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_P = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;

  // Advance a pointer; toggling the wrap bit on the last slot keeps
  // non-power-of-two depths correct.
  function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
    if (p[AW-1:0] == LAST) begin
      return {~p[AW], {AW{1'b0}}};
    end
    return p + (AW + 1)'(1);
  endfunction

  // Next-pointer selection
  always_comb begin
    wptr_d = wr_en ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = rd_en ? ptr_inc(rptr_q) : rptr_q;
  end

  // Occupancy from the wrap-bit pointer pair
  always_comb begin
    if (wptr_q[AW] == rptr_q[AW]) begin
      occ = {1'b0, wptr_q[AW-1:0]} - {1'b0, rptr_q[AW-1:0]};
    end else begin
      occ = DEPTH_P - {1'b0, rptr_q[AW-1:0]} + {1'b0, wptr_q[AW-1:0]};
    end
  end

  assign rd_data = mem_q[rptr_q[AW-1:0]];

  // Storage and pointer registers; reset flushes contents as well
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (wr_en) begin
        mem_q[wptr_q[AW-1:0]] <= wr_data;
      end
    end
  end

  // Upstream issue logic must never overfill or underflow the buffer
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      assert (occ != DEPTH_P);
    end
    if (!rst && rd_en) begin
      assert (occ != '0);
    end
  end

endmodule

// File: rtl/fifo_priority_drain.sv
// Drain stage for the dual-priority FIFO: issues reads, absorbs the
// one-cycle read latency, re-presents words as a valid/ready stream
// tagged with their source queue, and flags LP starvation.
// Optional per-source handoff counters: define DRAIN_STATS_EN.
module fifo_priority_drain
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned OUT_DEPTH  = 2,
  parameter int unsigned STARVE_LIM = 64,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_hp_empty,
  input  logic                  fifo_lp_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_src,
  output logic                  lp_starve
`ifdef DRAIN_STATS_EN
  ,
  output logic [CNT_W-1:0]      hp_words,
  output logic [CNT_W-1:0]      lp_words
`endif
);

  localparam int unsigned      OW  = ptr_w(OUT_DEPTH) + 1;
  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

  logic [OW-1:0]       occ;
  logic [OW:0]         demand;
  logic [DATA_WIDTH:0] head;
  logic                pop;
  logic                rd_issue;
  logic                lp_read;
  logic                infl_q, infl_d;
  logic                src_q, src_d;
  logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
  logic                lp_starve_q, lp_starve_d;

  // Output view of the buffer head; everything reads as zero during reset
  always_comb begin
    m_valid = !rst && (occ != '0);
    m_data  = rst ? '0 : head[DATA_WIDTH-1:0];
    m_src   = !rst && head[DATA_WIDTH];
  end

  // Issue a read only if the word it returns is guaranteed a free slot,
  // counting the word already in flight and any pop this cycle.
  always_comb begin
    pop      = m_valid && m_ready;
    demand   = (OW + 1)'(occ) + (OW + 1)'(infl_q) - (OW + 1)'(pop);
    rd_issue = !rst && !(fifo_hp_empty && fifo_lp_empty)
               && (demand < (OW + 1)'(OUT_DEPTH));
    lp_read  = rd_issue && fifo_hp_empty;
    infl_d   = rd_issue;
    src_d    = src_q;
    if (rd_issue) begin
      src_d = fifo_hp_empty ? SRC_LP : SRC_HP;
    end
  end

  assign fifo_rd_en = rd_issue;

  // In-flight flag and source tag of the outstanding read
  always_ff @(posedge clk) begin
    if (rst) begin
      infl_q <= 1'b0;
      src_q  <= SRC_LP;
    end else begin
      infl_q <= infl_d;
      src_q  <= src_d;
    end
  end

  drain_out_buf #(
    .DEPTH (OUT_DEPTH),
    .WIDTH (DATA_WIDTH + 1)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (infl_q),
    .wr_data ({src_q, fifo_dout}),
    .rd_en   (pop),
    .rd_data (head),
    .occ     (occ)
  );

  // Starvation counter: consecutive cycles LP waits without being read
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (fifo_lp_empty || lp_read) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q < LIM) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
    lp_starve_d = (starve_cnt_d == LIM);
  end

  // Starvation state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
      lp_starve_q  <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      lp_starve_q  <= lp_starve_d;
    end
  end

  assign lp_starve = lp_starve_q && !rst;

`ifdef DRAIN_STATS_EN
  logic [CNT_W-1:0] hp_words_q;
  logic [CNT_W-1:0] lp_words_q;

  // Saturating handoff counters per source queue
  always_ff @(posedge clk) begin
    if (rst) begin
      hp_words_q <= '0;
      lp_words_q <= '0;
    end else if (pop) begin
      if (m_src == SRC_HP) begin
        if (hp_words_q != '1) begin
          hp_words_q <= hp_words_q + CNT_W'(1);
        end
      end else begin
        if (lp_words_q != '1) begin
          lp_words_q <= lp_words_q + CNT_W'(1);
        end
      end
    end
  end

  assign hp_words = hp_words_q;
  assign lp_words = lp_words_q;
`endif

endmodule

// File: tb/tb_fifo_priority_drain.sv
// Bench for fifo_priority_drain: a queue-based priority FIFO drives the
// DUT, a scoreboard checks stream order/tags, handshake stability and the
// starvation flag every cycle, and directed sequences pin exact timing.
module tb_fifo_priority_drain;

  localparam int unsigned DW  = 16;
  localparam int unsigned LIM = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hp_empty = 1'b1;
  logic          lp_empty = 1'b1;
  logic          rd_en;
  logic [DW-1:0] dout = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_src;
  logic          lp_starve;
`ifdef DRAIN_STATS_EN
  logic [15:0]   hp_words;
  logic [15:0]   lp_words;
`endif

  always #5 clk = ~clk;

  fifo_priority_drain #(
    .DATA_WIDTH (DW),
    .OUT_DEPTH  (2),
    .STARVE_LIM (LIM),
    .CNT_W      (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fifo_hp_empty (hp_empty),
    .fifo_lp_empty (lp_empty),
    .fifo_rd_en    (rd_en),
    .fifo_dout     (dout),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_src         (m_src),
    .lp_starve     (lp_starve)
`ifdef DRAIN_STATS_EN
    ,
    .hp_words      (hp_words),
    .lp_words      (lp_words)
`endif
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Priority FIFO environment: HP first, data one cycle after the strobe
  logic [DW-1:0] hpq[$];
  logic [DW-1:0] lpq[$];
  logic [DW:0]   expq[$];
  logic [DW-1:0] emu_w;
  logic          hp_feed = 1'b0;
  int unsigned   feed_n = 0;

  always @(posedge clk) begin
    if (rst) begin
      hpq.delete();
      lpq.delete();
      expq.delete();
      hp_empty <= 1'b1;
      lp_empty <= 1'b1;
    end else begin
      if (rd_en) begin
        if (!hp_empty) begin
          emu_w = hpq.pop_front();
          expq.push_back({1'b1, emu_w});
        end else begin
          emu_w = lpq.pop_front();
          expq.push_back({1'b0, emu_w});
        end
        dout <= emu_w;
      end
      hp_empty <= (hpq.size() == 0);
      lp_empty <= (lpq.size() == 0);
    end
  end

  always @(posedge clk) begin
    #1;
    if (hp_feed) begin
      hpq.push_back(16'hC000 + 16'(feed_n));
      feed_n++;
    end
  end

  // Reference starvation state: length of the current run of cycles in
  // which LP had data but the read that went out (if any) was not LP's.
  int  streak = 0;
  logic rst_edge = 1'b1;

  always @(posedge clk) begin
    rst_edge = rst;
    if (rst || lp_empty || (rd_en && hp_empty)) streak = 0;
    else streak = streak + 1;
  end

  // Per-cycle compare process
  logic        mon_en = 1'b0;
  logic        prev_v = 1'b0;
  logic        prev_r = 1'b0;
  logic [DW:0] prev_w = '0;
  logic [DW:0] mon_w;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_edge) begin
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_m_src", 32'(m_src), 32'd0);
        chk("rst_lp_starve", 32'(lp_starve), 32'd0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        prev_v = 1'b0;
        prev_r = 1'b0;
      end else begin
        chk("rd_when_empty", 32'(rd_en && hp_empty && lp_empty), 32'd0);
        if (prev_v && !prev_r) begin
          chk("hold_valid", 32'(m_valid), 32'd1);
          chk("hold_word", 32'({m_src, m_data}), 32'(prev_w));
        end
        if (m_valid && m_ready) begin
          if (expq.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL sb_word: got %h want <none>", {m_src, m_data});
          end else begin
            mon_w = expq.pop_front();
            chk("sb_word", 32'({m_src, m_data}), 32'(mon_w));
          end
        end
        chk("lp_starve", 32'(lp_starve), 32'(streak >= int'(LIM)));
        prev_v = m_valid;
        prev_r = m_ready;
        prev_w = {m_src, m_data};
      end
    end
  end

  task automatic drive_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_cycle();
    rst = 1'b1;
    hp_feed = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Wait (bounded) for the next negedge with a strobe; returns 1 if seen
  task automatic wait_rd(input bit lp_only, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rd_en && (!lp_only || hp_empty)) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int reads;
    int n;

    // 1: idle after reset
    @(negedge clk);
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t1_rd_en", 32'(rd_en), 32'd0);
      chk("t1_m_valid", 32'(m_valid), 32'd0);
      chk("t1_outputs", 32'({m_src, m_data, lp_starve}), 32'd0);
    end

    // 2: HP {A1,A2}, LP {B1} drain back-to-back, HP first
    drive_cycle();
    hpq.push_back(16'hA001);
    hpq.push_back(16'hA002);
    lpq.push_back(16'hB001);
    wait_rd(1'b0, seen);
    chk("t2_issue_seen", 32'(seen), 32'd1);
    @(negedge clk);
    chk("t2_no_bypass", 32'(m_valid), 32'd0);
    @(negedge clk);
    chk("t2_w0", 32'({m_valid, m_src, m_data}), 32'h3A001);
    @(negedge clk);
    chk("t2_w1", 32'({m_valid, m_src, m_data}), 32'h3A002);
    @(negedge clk);
    chk("t2_w2", 32'({m_valid, m_src, m_data}), 32'h2B001);
    @(negedge clk);
    chk("t2_idle", 32'(m_valid), 32'd0);

    // 3: backpressure fills the buffer after exactly two reads
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) lpq.push_back(16'h3000 + 16'(i));
    reads = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rd_en) reads++;
    end
    chk("t3_reads", 32'(reads), 32'd2);
    chk("t3_full", 32'(dut.occ), 32'd2);
    chk("t3_head", 32'({m_valid, m_src, m_data}), 32'h23000);
    drive_cycle();
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t3_stream", 32'({m_valid, m_src, m_data}), 32'h23000 + 32'(i));
    end
    @(negedge clk);
    chk("t3_idle", 32'(m_valid), 32'd0);

    // 4: LP starves under continuous HP traffic
    do_reset();
    lpq.push_back(16'h4444);
    hpq.push_back(16'hC0FF);
    hp_feed = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!lp_empty) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t4_lp_visible", 32'(seen), 32'd1);
    n = 0;
    while (!lp_starve && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("t4_starve_cycles", 32'(n), 32'd64);
    drive_cycle();
    hp_feed = 1'b0;
    wait_rd(1'b1, seen);
    chk("t4_lp_read", 32'(seen), 32'd1);
    chk("t4_starve_at_read", 32'(lp_starve), 32'd1);
    @(negedge clk);
    chk("t4_starve_clear", 32'(lp_starve), 32'd0);
    repeat (6) @(negedge clk);
    chk("t4_drained", 32'(expq.size()), 32'd0);
    chk("t4_idle", 32'(m_valid), 32'd0);

    // 5: reset with one word buffered and one in flight
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) lpq.push_back(16'h5000 + 16'(i));
    wait_rd(1'b0, seen);
    chk("t5_first_rd", 32'(seen), 32'd1);
    @(negedge clk);
    chk("t5_second_rd", 32'(rd_en), 32'd1);
    drive_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("t5_pre_state", 32'({dut.infl_q, dut.occ}), 32'({1'b1, 2'd1}));
    chk("t5_gated_valid", 32'(m_valid), 32'd0);
    drive_cycle();
    rst = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    chk("t5_occ", 32'(dut.occ), 32'd0);
    chk("t5_valid", 32'(m_valid), 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t5_no_stale", 32'({m_valid, rd_en}), 32'd0);
    end

`ifdef DRAIN_STATS_EN
    // 6: per-source handoff counters and saturation
    do_reset();
    for (int i = 0; i < 3; i++) hpq.push_back(16'h6100 + 16'(i));
    for (int i = 0; i < 5; i++) lpq.push_back(16'h6200 + 16'(i));
    repeat (20) @(negedge clk);
    chk("t6_hp_words", 32'(hp_words), 32'd3);
    chk("t6_lp_words", 32'(lp_words), 32'd5);
    drive_cycle();
    force dut.hp_words_q = 16'hFFFF;
    #1;
    release dut.hp_words_q;
    hpq.push_back(16'h6300);
    repeat (8) @(negedge clk);
    chk("t6_hp_sat", 32'(hp_words), 32'h0000FFFF);
    chk("t6_lp_hold", 32'(lp_words), 32'd5);
`endif

    repeat (2) @(negedge clk);
    chk("end_sb_empty", 32'(expq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
